// File: rtl/seq_detect_param_pkg.sv
// rtl/seq_detect_param_pkg.sv - shared defaults and width helper for seq_detect_param
package seq_detect_pkg;

  localparam logic [7:0] DEF_PAT = 8'b0001_0101;
  localparam int         DEF_LEN = 5;
  localparam bit         DEF_OVL = 1'b0;

  // Bits needed to hold a length in 0..pat_w inclusive.
  function automatic int LEN_W(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - stream, config and result bundle (SEQ_DETECT_STICKY_EN adds match_sticky)
interface seq_detect_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LW = seq_detect_pkg::LEN_W(PAT_W);

  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             count_clr;
  logic             match;
  logic [CNT_W-1:0] match_count;
`ifdef SEQ_DETECT_STICKY_EN
  logic             match_sticky;
`endif

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
`ifdef SEQ_DETECT_STICKY_EN
    input  match_sticky,
`endif
    input  match, match_count
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
`ifdef SEQ_DETECT_STICKY_EN
    output match_sticky,
`endif
    output match, match_count
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// rtl/seq_detect_param_sat_counter.sv - saturating up counter with clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // A clear coinciding with an increment leaves the counter at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-configurable serial pattern detector (optional SEQ_DETECT_STICKY_EN)
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_detect_pkg::DEF_PAT),
  parameter int               DEF_LEN = seq_detect_pkg::DEF_LEN,
  parameter bit               DEF_OVL = seq_detect_pkg::DEF_OVL
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);

  localparam int LW = LEN_W(PAT_W);

  logic [PAT_W-1:0] pattern;
  logic [LW-1:0]    len;
  logic             overlap;
  logic [PAT_W-2:0] sr;
  logic [LW-1:0]    fill;
  logic             match_q;

  logic [PAT_W-1:0] sr_n;
  logic [LW-1:0]    fill_n;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    len_ld;
  logic             hit;

  // The oldest history bit is only ever needed for the current compare, so sr keeps PAT_W-1 bits.
  always_comb begin
    sr_n   = {sr, bus.in_bit};
    fill_n = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
    mask   = ~({PAT_W{1'b1}} << len);
    hit    = (len != '0) && (fill_n >= len) && (((sr_n ^ pattern) & mask) == '0);
    len_ld = (bus.cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : bus.cfg_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= DEF_PAT;
      len     <= LW'(DEF_LEN);
      overlap <= DEF_OVL;
      sr      <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (bus.cfg_load) begin
      pattern <= bus.cfg_pattern;
      len     <= len_ld;
      overlap <= bus.cfg_overlap;
      sr      <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (bus.in_valid) begin
      sr      <= sr_n[PAT_W-2:0];
      fill    <= (hit && !overlap) ? '0 : fill_n;
      match_q <= hit;
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match = match_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_q),
    .clr   (bus.count_clr),
    .count (bus.match_count)
  );

`ifdef SEQ_DETECT_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (bus.cfg_load) begin
      sticky_q <= 1'b0;
    end else if (bus.in_valid && hit) begin
      sticky_q <= 1'b1;
    end else if (bus.count_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.match_sticky = sticky_q;
`endif

endmodule
